// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time configurable serial pattern detector.
// It shifts qualified input bits into a history register and compares the
// newest len_r bits against the loaded pattern. A match raises a one-cycle
// registered pulse and increments a saturating counter. Non-overlap mode
// restarts the fill count after each match.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           in_valid,
  input  logic                           in,
  output logic                           out,
  output logic [CNT_W-1:0]               match_count
);

  localparam int                 LEN_W   = $clog2(MAX_LEN+1);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(4);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b0110);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  // Counter increment that holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Fill count increment that holds at MAX_LEN.
  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
    return (f >= LEN_MAX) ? LEN_MAX : f + LEN_W'(1);
  endfunction

  // Lengths beyond the history depth are limited to the full depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  // Next history and fill, and the match decision on that updated state.
  always_comb begin
    w_hist_nxt = (r_hist << 1) | {{(MAX_LEN-1){1'b0}}, in};
    w_fill_nxt = fill_inc(r_fill);
    w_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_match = (r_len != '0) && (w_fill_nxt >= r_len) &&
              ((w_hist_nxt & w_mask) == (r_pat & w_mask));
  end

  // Configuration capture, history shifting, match pulse and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PAT_RST;
      r_len  <= LEN_RST;
      r_ovl  <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= clamp_len(cfg_len);
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else if (in_valid) begin
      r_hist <= w_hist_nxt;
      r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nxt;
      r_out  <= w_match;
      if (w_match) r_cnt <= sat_inc(r_cnt);
    end else begin
      r_out  <= 1'b0;
    end
  end

  assign out         = r_out;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Two instances share one stimulus:
// a default one (CNT_W=8) and a narrow-counter one (CNT_W=2) for saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in;
  logic       out8, out2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in), .out(out8), .match_count(cnt8)
  );

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in), .out(out2), .match_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    in_valid = 1'b1;
    in       = b;
    tick();
    in_valid = 1'b0;
    chk({tag, ".out"}, {31'b0, out8}, {31'b0, exp_out});
    chk({tag, ".out2"}, {31'b0, out2}, {31'b0, exp_out});
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    tick();
    chk({tag, ".gap_out"}, {31'b0, out8}, 32'd0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic v, input logic b);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    in_valid    = v;
    in          = b;
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("load.out", {31'b0, out8}, 32'd0);
    chk("load.cnt", {24'b0, cnt8}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.out", {31'b0, out8}, 32'd0);
    chk("rst.cnt", {24'b0, cnt8}, 32'd0);

    // Defaults: 0110 non-overlapping.
    send(0, 0, "t1b1"); send(1, 0, "t1b2"); send(1, 0, "t1b3"); send(0, 1, "t1b4");
    send(1, 0, "t1b5"); send(1, 0, "t1b6"); send(0, 0, "t1b7");
    chk("t1.cnt", {24'b0, cnt8}, 32'd1);

    // 0110 overlapping.
    load(8'h06, 4'd4, 1'b1, 1'b0, 1'b0);
    send(0, 0, "t2b1"); send(1, 0, "t2b2"); send(1, 0, "t2b3"); send(0, 1, "t2b4");
    send(1, 0, "t2b5"); send(1, 0, "t2b6"); send(0, 1, "t2b7");
    chk("t2.cnt", {24'b0, cnt8}, 32'd2);

    // Single-bit pattern, non-overlapping: continuous pulses.
    load(8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
    send(1, 1, "t3b1"); send(1, 1, "t3b2"); send(1, 1, "t3b3");
    chk("t3.cnt", {24'b0, cnt8}, 32'd3);

    // Defaults with in_valid gaps.
    do_reset();
    chk("t4.rst_cnt", {24'b0, cnt8}, 32'd0);
    send(0, 0, "t4b1"); idle("t4g1"); idle("t4g1"); idle("t4g1");
    send(1, 0, "t4b2"); idle("t4g2"); idle("t4g2"); idle("t4g2");
    send(1, 0, "t4b3"); idle("t4g3"); idle("t4g3"); idle("t4g3");
    send(0, 1, "t4b4");
    idle("t4after");
    chk("t4.cnt", {24'b0, cnt8}, 32'd1);

    // Counter saturation on the narrow instance.
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send(1, 1, "t5b");
    chk("t5.cnt8", {24'b0, cnt8}, 32'd6);
    chk("t5.cnt2", {30'b0, cnt2}, 32'd3);

    // Zero length disables detection.
    load(8'h01, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("t5.cnt2_clr", {30'b0, cnt2}, 32'd0);
    send(1, 0, "t5z1"); send(1, 0, "t5z2"); send(1, 0, "t5z3");
    chk("t5.zcnt", {24'b0, cnt8}, 32'd0);

    // Reset mid-pattern loses the partial match.
    do_reset();
    send(0, 0, "t6a1"); send(1, 0, "t6a2"); send(1, 0, "t6a3");
    do_reset();
    chk("t6.rst_out", {31'b0, out8}, 32'd0);
    send(0, 0, "t6a4");
    send(0, 0, "t6b1"); send(1, 0, "t6b2"); send(1, 0, "t6b3"); send(0, 1, "t6b4");
    chk("t6.cnt", {24'b0, cnt8}, 32'd1);

    // A bit presented with cfg_load is discarded.
    load(8'h06, 4'd4, 1'b0, 1'b1, 1'b0);
    send(1, 0, "t6c1"); send(1, 0, "t6c2"); send(0, 0, "t6c3");
    send(1, 0, "t6c4"); send(1, 0, "t6c5"); send(0, 1, "t6c6");
    chk("t6c.cnt", {24'b0, cnt8}, 32'd1);

    // Over-long length clamps to the full history depth.
    load(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0);
    send(1, 0, "t7b1"); send(0, 0, "t7b2"); send(1, 0, "t7b3"); send(0, 0, "t7b4");
    send(0, 0, "t7b5"); send(1, 0, "t7b6"); send(0, 0, "t7b7"); send(1, 1, "t7b8");
    chk("t7.cnt", {24'b0, cnt8}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
